// File: rtl/mt_stream_gen_if.sv
// rtl/mt_stream_gen_if.sv - valid/ready output stream of the Mersenne-Twister generator
//
// Purpose: carries one tempered random word per transfer (out_valid & out_ready).
// Ports (via modports):
//   master: drives out_valid, out_data; samples out_ready
//   slave : samples out_valid, out_data; drives out_ready
interface mt_stream_gen_if #(
  parameter int unsigned W = 32
) ();
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/mt_stream_gen.sv
// rtl/mt_stream_gen.sv - parametrised Mersenne-Twister generator with streaming output
//
// Purpose: seeds an N-word state array (one word per cycle), then twists one
// state word per output, tempers it and streams it at up to one word per cycle.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset (restarts from SEED_DEFAULT)
//   seed_load  one-cycle pulse: reseed with `seed` from any state
//   seed       W-bit seed, sampled while seed_load=1
//   busy       1 while seeding / priming, 0 exactly while streaming
//   out_if     master side of the output stream (out_valid/out_ready/out_data)
module mt_stream_gen #(
  parameter int unsigned  W            = 32,
  parameter int unsigned  N            = 624,
  parameter int unsigned  M            = 397,
  parameter int unsigned  R            = 31,
  parameter logic [W-1:0] A            = 'h9908B0DF,
  parameter int unsigned  U            = 11,
  parameter logic [W-1:0] D            = 'hFFFFFFFF,
  parameter int unsigned  S            = 7,
  parameter logic [W-1:0] B            = 'h9D2C5680,
  parameter int unsigned  T            = 15,
  parameter logic [W-1:0] C            = 'hEFC60000,
  parameter int unsigned  L            = 18,
  parameter logic [W-1:0] F            = 'd1812433253,
  parameter logic [W-1:0] SEED_DEFAULT = 'd5489
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_load,
  input  logic [W-1:0]    seed,
  output logic            busy,
  mt_stream_gen_if.master out_if
);

  localparam int unsigned   IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {ST_SEED, ST_FILL, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  seed_q, seed_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  // State array: flop-based so all three twist operands are read in the same
  // cycle the new word is written; a word written at i is therefore visible to
  // the very next read of i, which removes any read-after-write hazard.
  logic [W-1:0]  mt_mem [N];
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;

  logic [IW-1:0] idx_1, idx_m;
  logic [IW:0]   sum_m;
  logic [W-1:0]  gen_x, gen_word, seed_word;

  function automatic logic [W-1:0] temper(input logic [W-1:0] v);
    logic [W-1:0] y;
    y = v ^ ((v >> U) & D);
    y = y ^ ((y << S) & B);
    y = y ^ ((y << T) & C);
    y = y ^ (y >> L);
    return y;
  endfunction

  // Twist operands and the seeding recurrence. Indices wrap at N, not at 2^IW.
  always_comb begin
    idx_1     = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    sum_m     = {1'b0, idx_q} + (IW+1)'(M);
    idx_m     = (sum_m >= (IW+1)'(N)) ? IW'(sum_m - (IW+1)'(N)) : IW'(sum_m);
    gen_x     = {mt_mem[idx_q][W-1:R], mt_mem[idx_1][R-1:0]};
    gen_word  = mt_mem[idx_m] ^ (gen_x >> 1) ^ (gen_x[0] ? A : '0);
    seed_word = (cnt_q == '0) ? seed_q
                              : F * (prev_q ^ (prev_q >> (W - 2))) + W'(cnt_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    prev_d      = prev_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mem_we      = 1'b0;
    mem_waddr   = idx_q;
    mem_wdata   = gen_word;

    if (seed_load) begin
      // Any word presented this cycle still transfers if out_ready is high.
      state_d     = ST_SEED;
      cnt_d       = '0;
      seed_d      = seed;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      unique case (state_q)
        ST_SEED: begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = seed_word;
          prev_d    = seed_word;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FILL, ST_RUN: begin
          // FILL unconditionally produces the first word; RUN only refills the
          // output register when it is empty or being taken this cycle.
          if (state_q == ST_FILL || !out_valid_q || out_if.out_ready) begin
            mem_we      = 1'b1;
            out_data_d  = temper(gen_word);
            out_valid_d = 1'b1;
            idx_d       = idx_1;
            state_d     = ST_RUN;
          end
        end
        default: state_d = ST_SEED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEED;
      cnt_q       <= '0;
      idx_q       <= '0;
      seed_q      <= SEED_DEFAULT;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      prev_q      <= prev_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The array needs no reset: SEED rewrites every word before it is read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mt_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy             = (state_q != ST_RUN);
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;

endmodule
